// File: rtl/ssram_pkg.sv
// Shared types and helpers for the ssram register bank.
package ssram_pkg;

    typedef enum logic {
        SSRAM_IDLE = 1'b0,
        SSRAM_ACK  = 1'b1
    } ssram_state_e;

    // Widest word the mask helper handles; callers zero-extend and slice.
    localparam int SSRAM_MAXW = 1024;
    localparam int SSRAM_MAXB = SSRAM_MAXW / 8;

    function automatic logic [SSRAM_MAXW-1:0] ssram_be_mask(
        input logic [SSRAM_MAXB-1:0] be
    );
        logic [SSRAM_MAXW-1:0] m;
        m = '0;
        for (int k = 0; k < SSRAM_MAXB; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ssram_bank_if.sv
// Request/acknowledge bus between the CPU bridge and the register bank.
interface ssram_bank_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 16
);
    logic               req;
    logic               we;
    logic [AW-1:0]      addr;
    logic [WIDTH/8-1:0] be;
    logic [WIDTH-1:0]   wdata;
    logic               ack;
    logic               err;
    logic [WIDTH-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/ssram_word.sv
// One bank word: byte-masked write, asynchronous reset to RST_VAL.
module ssram_word #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = (q_q & ~mask_i) | (wdata_i & mask_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (we_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/ssram_bank.sv
// WIDTH x DEPTH register bank with req/ack access, byte enables,
// range checking and a parallel view of every word.
module ssram_bank
    import ssram_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               DEPTH   = 256,
    parameter int               AW      = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    ssram_bank_if.slave      bus,
    output logic [WIDTH-1:0] out [DEPTH],
    output logic [DEPTH-1:0] upd
);
    ssram_state_e state_q, state_d;

    logic                  take;
    logic                  in_range;
    logic                  any_be;
    logic [DEPTH-1:0]      hit;
    logic [DEPTH-1:0]      wr_en;
    logic [SSRAM_MAXB-1:0] be_ext;
    logic [SSRAM_MAXW-1:0] mask_full;
    logic                  unused_mask;
    logic [WIDTH-1:0]      mask;
    logic [WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]      merged;

    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q;
    logic [DEPTH-1:0] upd_q;

    // Requests are only taken in IDLE; a req seen in ACK waits a cycle.
    assign take     = (state_q == SSRAM_IDLE) && bus.req;
    assign in_range = ({{(32-AW){1'b0}}, bus.addr} < 32'(DEPTH));
    assign any_be   = |bus.be;

    assign be_ext      = SSRAM_MAXB'(bus.be);
    assign mask_full   = ssram_be_mask(be_ext);
    assign mask        = mask_full[WIDTH-1:0];
    assign unused_mask = ^mask_full;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign hit[i]   = (bus.addr == AW'(i));
        assign wr_en[i] = take && bus.we && any_be && hit[i];

        ssram_word #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_word (
            .clk     (clk),
            .rst     (rst),
            .we_i    (wr_en[i]),
            .mask_i  (mask),
            .wdata_i (bus.wdata),
            .q_o     (out[i])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                rd_word = out[i];
            end
        end
    end

    // A write returns the word as it will read after the update.
    assign merged = (rd_word & ~mask) | (bus.wdata & mask);

    always_comb begin
        rdata_d = '0;
        if (in_range) begin
            rdata_d = bus.we ? merged : rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            upd_q   <= '0;
        end else begin
            upd_q <= wr_en;
            if (take) begin
                rdata_q <= rdata_d;
                err_q   <= !in_range;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SSRAM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SSRAM_IDLE: if (bus.req) state_d = SSRAM_ACK;
            SSRAM_ACK:  state_d = SSRAM_IDLE;
            default:    state_d = SSRAM_IDLE;
        endcase
    end

    always_comb begin
        bus.ack   = (state_q == SSRAM_ACK);
        bus.err   = err_q;
        bus.rdata = rdata_q;
        upd       = upd_q;
    end
endmodule
